mcs4_pc_stack: RTL and testbench
================================

// Module: mcs4_pc_stack
// PURPOSE
//  Parametrised program-counter and subroutine-stack unit for the next-gen MCS-4 core.
//  Generalises the fixed 12b PC / 3-level stack to configurable ADDR_W and STACK_DEPTH (4004: 3, 4040: 7).
//  Adds depth reporting, overflow/underflow indication and page-relative jumps.
//  Sits between instruction decode (command source) and the dbus arbiter (address-nibble consumer).
// PARAMETERS
//  ADDR_W       12  PC width in bits; multiple of 4, 12..16
//  STACK_DEPTH  3   return-address entries, 1..8
//  RST_PC       0   PC value after reset
// PORTS
//  clk         in   1                      core clock
//  rst_n       in   1                      asynchronous, active-low reset
//  icyc_i      in   mcs4::instr_cyc_t      current instruction sub-cycle (A1..X3)
//  cmd_valid_i in   1                      command present; sampled only when icyc_i==X2
//  cmd_i       in   mcs4::pc_cmd_t         INC / JUMP / PAGE / CALL / RET
//  cmd_addr_i  in   ADDR_W                 target (JUMP/CALL: full; PAGE: bits [7:0] used)
//  nib_sel_i   in   $clog2(ADDR_W/4)       nibble index for addr_nib_o (0 = least significant)
//  pc_o        out  ADDR_W                 current program counter
//  addr_nib_o  out  4                      pc_o[4*nib_sel_i +: 4], combinational
//  depth_o     out  $clog2(STACK_DEPTH+1)  occupied stack entries
//  ovf_o       out  1                      1-clk pulse: CALL with depth_o==STACK_DEPTH
//  unf_o       out  1                      1-clk pulse: RET with depth_o==0
//  err_o       out  1                      sticky error (macro only; else tied 0)
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_o=RST_PC; depth_o=0; ovf_o=unf_o=err_o=0; all stack entries cleared to 0; write pointer 0.
//  - Reset mid-cycle aborts any sampled command: no push, pop or PC change survives.
//  Two-stage per instruction cycle:
//  - Edge with icyc_i==X2: compute next_pc (registered) and pending stack op.
//  - Edge with icyc_i==X3: pc_o<=next_pc; stack/depth update; ovf_o/unf_o asserted for exactly the following clock.
//  - Commands outside X2 are ignored. Edges at other phases: all state holds.
//  inc = pc_o+1 mod 2^ADDR_W, so 0xFFF -> 0x000 at ADDR_W=12.
//  Command semantics (cmd_valid_i=0 behaves as INC):
//  - INC: next_pc=inc.
//  - JUMP: next_pc=cmd_addr_i.
//  - PAGE: next_pc={inc[ADDR_W-1:8], cmd_addr_i[7:0]}. End-of-page carry comes from the incremented PC.
//  - CALL: push inc (return address), next_pc=cmd_addr_i, depth_o+1.
//  - RET: pop; next_pc=top entry, depth_o-1.
//  Stack: circular, STACK_DEPTH slots, write pointer wraps modulo STACK_DEPTH.
//  - CALL when full: overwrite oldest slot; depth_o stays STACK_DEPTH; ovf_o pulse.
//  - RET when empty: pointer still decrements (wraps) and loads that slot; depth_o stays 0; unf_o pulse.
//  - One command per instruction cycle, so push and pop are never simultaneous.
// CONFIGURATION
//  MCS4_PCSTACK_GUARD_EN defined:
//  - CALL when full: no write, pointer and depth unchanged, PC still jumps.
//  - RET when empty: next_pc=inc.
//  - err_o set on either condition and held until reset. ovf_o/unf_o pulse as before.
//  Undefined: circular behaviour above; err_o tied 0.
// STRUCTURE
//  Package mcs4 gains:
//  - pc_cmd_t enum {PC_INC, PC_JUMP, PC_PAGE, PC_CALL, PC_RET}.
//  - Stack_depth_4004=3, Stack_depth_4040=7, Page_bits=8.
//  Sub-module mcs4_addr_incr: ADDR_W-bit lookahead incrementer producing inc and carry-out.
//  Stack is a register array, not inferred RAM.
// TESTING
//  All scenarios use ADDR_W=12, STACK_DEPTH=3 unless noted.
//  1 Reset, 8 idle instr cycles -> pc_o 0x001..0x008; 0xFFF + INC -> 0x000; addr_nib_o(sel=2) of 0x3A5 -> 0x3.
//  2 PAGE 0x34 at pc 0x1FF -> 0x234; at pc 0x150 -> 0x134; JUMP 0xABC -> 0xABC.
//  3 CALL 0x300 at pc 0x010 -> pc 0x300, depth 1; RET -> pc 0x011, depth 0, no pulses.
//  4 CALLs from pc 0x100, 0x200, 0x300, 0x400 -> ovf_o on 4th, depth 3; three RETs -> 0x401, 0x301, 0x201; 4th RET -> unf_o, pc 0x401.
//  5 rst_n low at X2 edge with CALL pending -> pc_o 0 immediately, depth 0, no push after release.
//  6 GUARD_EN: 4th CALL -> err_o=1, stack intact, RETs -> 0x301, 0x201, 0x101; extra RET -> pc=inc.

Source files
------------

// File: rtl/mcs4_pc_stack_pkg.sv
// Shared types and constants for the MCS-4 program-counter / subroutine-stack unit.
// Contents: instruction sub-cycle enum, PC command enum, internal pending-op payload,
// stack depth presets for the 4004 and 4040, and the page width used by PAGE jumps.
package mcs4_pc_stack_pkg;

    localparam int unsigned Stack_depth_4004 = 3;
    localparam int unsigned Stack_depth_4040 = 7;
    localparam int unsigned Page_bits        = 8;

    // Eight-phase instruction cycle: three address, two memory, three execute phases.
    typedef enum logic [2:0] {
        CYC_A1, CYC_A2, CYC_A3, CYC_M1, CYC_M2, CYC_X1, CYC_X2, CYC_X3
    } instr_cyc_t;

    typedef enum logic [2:0] {
        PC_INC, PC_JUMP, PC_PAGE, PC_CALL, PC_RET
    } pc_cmd_t;

    typedef enum logic [1:0] {
        OP_NONE, OP_PUSH, OP_POP
    } stack_op_t;

    // Work decided at X2 and committed at X3.
    typedef struct packed {
        logic      vld;
        stack_op_t op;
        logic      ovf;
        logic      unf;
    } pc_pend_t;

endpackage

// File: rtl/mcs4_addr_incr.sv
// ADDR_W-bit incrementer with nibble-group carry lookahead.
// Ports:
//   a    in   ADDR_W   value to increment
//   inc  out  ADDR_W   a + 1 modulo 2^ADDR_W
//   co   out  1        carry out (a was all ones)
module mcs4_addr_incr #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] a,
    output logic [ADDR_W-1:0] inc,
    output logic              co
);

    localparam int unsigned NIB_N = ADDR_W / 4;

    logic [NIB_N:0] cin;

    // A nibble receives the carry only when every lower nibble is all ones.
    always_comb begin
        cin    = '0;
        cin[0] = 1'b1;
        inc    = '0;
        for (int g = 0; g < int'(NIB_N); g++) begin
            cin[g+1]      = cin[g] & (&a[4*g +: 4]);
            inc[4*g +: 4] = a[4*g +: 4] + {3'b000, cin[g]};
        end
        co = cin[NIB_N];
    end

endmodule

// File: rtl/mcs4_pc_stack.sv
// Program counter and circular subroutine stack for the MCS-4 core.
// A command is decoded on the X2 edge and committed on the X3 edge; all other
// phases hold state. Optional macro MCS4_PCSTACK_GUARD_EN turns stack overflow
// and underflow into no-ops and enables the sticky err_o flag.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   icyc_i        instruction sub-cycle
//   cmd_valid_i   command present (sampled at X2 only)
//   cmd_i         INC / JUMP / PAGE / CALL / RET
//   cmd_addr_i    target address (PAGE uses the low page bits)
//   nib_sel_i     nibble select for addr_nib_o
//   pc_o          program counter
//   addr_nib_o    selected PC nibble (combinational)
//   depth_o       occupied stack entries
//   ovf_o, unf_o  one-clock overflow / underflow pulses
//   err_o         sticky error (guard build only, else 0)
module mcs4_pc_stack
    import mcs4_pc_stack_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned STACK_DEPTH = 3,
    parameter int unsigned RST_PC      = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  instr_cyc_t                         icyc_i,
    input  logic                               cmd_valid_i,
    input  pc_cmd_t                            cmd_i,
    input  logic [ADDR_W-1:0]                  cmd_addr_i,
    input  logic [$clog2(ADDR_W/4)-1:0]        nib_sel_i,
    output logic [ADDR_W-1:0]                  pc_o,
    output logic [3:0]                         addr_nib_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o,
    output logic                               ovf_o,
    output logic                               unf_o,
    output logic                               err_o
);

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  next_pc_q;
    logic [ADDR_W-1:0]  next_pc_d;
    logic [ADDR_W-1:0]  inc;
    logic               unused_inc_co;
    pc_pend_t           pend_q;
    pc_pend_t           pend_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_inc;
    logic [PTR_W-1:0]   ptr_dec;
    logic [DEPTH_W-1:0] depth_q;
    logic               full;
    logic               empty;
    logic               ovf_q;
    logic               unf_q;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    mcs4_addr_incr #(.ADDR_W(ADDR_W)) u_incr (
        .a   (pc_q),
        .inc (inc),
        .co  (unused_inc_co)
    );

    assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty   = (depth_q == '0);
    assign ptr_inc = (ptr_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign ptr_dec = (ptr_q == '0) ? PTR_W'(STACK_DEPTH - 1) : ptr_q - PTR_W'(1);

    // Command decode: target PC and the stack operation to commit at X3.
    always_comb begin
        next_pc_d  = inc;
        pend_d     = '0;
        pend_d.vld = 1'b1;
        pend_d.op  = OP_NONE;
        if (cmd_valid_i) begin
            case (cmd_i)
                PC_JUMP: next_pc_d = cmd_addr_i;
                PC_PAGE: next_pc_d = {inc[ADDR_W-1:Page_bits], cmd_addr_i[Page_bits-1:0]};
                PC_CALL: begin
                    next_pc_d  = cmd_addr_i;
                    pend_d.ovf = full;
`ifdef MCS4_PCSTACK_GUARD_EN
                    pend_d.op  = full ? OP_NONE : OP_PUSH;
`else
                    pend_d.op  = OP_PUSH;
`endif
                end
                PC_RET: begin
                    pend_d.unf = empty;
`ifdef MCS4_PCSTACK_GUARD_EN
                    if (!empty) begin
                        pend_d.op = OP_POP;
                        next_pc_d = stack_q[ptr_dec];
                    end
`else
                    // An empty pop still walks the pointer back and loads that slot.
                    pend_d.op = OP_POP;
                    next_pc_d = stack_q[ptr_dec];
`endif
                end
                default: next_pc_d = inc;
            endcase
        end
    end

    // Two-stage update: capture at X2, commit at X3, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= ADDR_W'(RST_PC);
            next_pc_q <= ADDR_W'(RST_PC);
            pend_q    <= '0;
            ptr_q     <= '0;
            depth_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            if (icyc_i == CYC_X2) begin
                next_pc_q <= next_pc_d;
                pend_q    <= pend_d;
            end else if (icyc_i == CYC_X3 && pend_q.vld) begin
                pc_q   <= next_pc_q;
                ovf_q  <= pend_q.ovf;
                unf_q  <= pend_q.unf;
                pend_q <= '0;
                case (pend_q.op)
                    OP_PUSH: begin
                        // pc_q is unchanged since X2, so inc is still the return address.
                        stack_q[ptr_q] <= inc;
                        ptr_q          <= ptr_inc;
                        if (!full) depth_q <= depth_q + DEPTH_W'(1);
                    end
                    OP_POP: begin
                        ptr_q <= ptr_dec;
                        if (!empty) depth_q <= depth_q - DEPTH_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MCS4_PCSTACK_GUARD_EN
    logic err_q;

    // Sticky record of any blocked overflow or underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (icyc_i == CYC_X3 && pend_q.vld && (pend_q.ovf || pend_q.unf)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign pc_o       = pc_q;
    assign depth_o    = depth_q;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;
    assign addr_nib_o = 4'(pc_q >> {nib_sel_i, 2'b00});

endmodule

// File: tb/tb_mcs4_pc_stack.sv
// Self-checking bench for mcs4_pc_stack (ADDR_W=12, STACK_DEPTH=3): directed
// scenarios plus randomized commands checked against a behavioural model.
module tb_mcs4_pc_stack;
    import mcs4_pc_stack_pkg::*;

    localparam int unsigned AW   = 12;
    localparam int unsigned SD   = 3;
    localparam int unsigned MASK = (1 << AW) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    instr_cyc_t icyc;
    logic       cmd_valid;
    pc_cmd_t    cmd;
    logic [AW-1:0] cmd_addr;
    logic [1:0] nib_sel;
    logic [AW-1:0] pc_o;
    logic [3:0] addr_nib_o;
    logic [1:0] depth_o;
    logic       ovf_o, unf_o, err_o;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: PC, circular return-address buffer, occupancy count.
    int unsigned m_pc, m_cnt, m_wp;
    int unsigned m_mem [SD];
    bit m_ovf, m_unf, m_err;

    mcs4_pc_stack #(.ADDR_W(AW), .STACK_DEPTH(SD), .RST_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icyc_i      (icyc),
        .cmd_valid_i (cmd_valid),
        .cmd_i       (cmd),
        .cmd_addr_i  (cmd_addr),
        .nib_sel_i   (nib_sel),
        .pc_o        (pc_o),
        .addr_nib_o  (addr_nib_o),
        .depth_o     (depth_o),
        .ovf_o       (ovf_o),
        .unf_o       (unf_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_wp = 0;
        m_ovf = 0; m_unf = 0; m_err = 0;
        for (int i = 0; i < int'(SD); i++) m_mem[i] = 0;
    endtask

    task automatic model_step(input bit v, input pc_cmd_t c, input int unsigned a);
        int unsigned inc;
        inc = (m_pc + 1) & MASK;
        m_ovf = 0;
        m_unf = 0;
        if (!v) begin
            m_pc = inc;
        end else begin
            case (c)
                PC_JUMP: m_pc = a & MASK;
                PC_PAGE: m_pc = (inc & ~32'hFF & MASK) | (a & 32'hFF);
                PC_CALL: begin
                    m_ovf = (m_cnt == SD);
`ifdef MCS4_PCSTACK_GUARD_EN
                    if (!m_ovf) begin
                        m_mem[m_wp] = inc;
                        m_wp = (m_wp + 1) % SD;
                        m_cnt++;
                    end
`else
                    m_mem[m_wp] = inc;
                    m_wp = (m_wp + 1) % SD;
                    if (m_cnt < SD) m_cnt++;
`endif
                    m_pc = a & MASK;
                end
                PC_RET: begin
                    m_unf = (m_cnt == 0);
`ifdef MCS4_PCSTACK_GUARD_EN
                    if (m_unf) begin
                        m_pc = inc;
                    end else begin
                        m_wp = (m_wp + SD - 1) % SD;
                        m_pc = m_mem[m_wp];
                        m_cnt--;
                    end
`else
                    m_wp = (m_wp + SD - 1) % SD;
                    m_pc = m_mem[m_wp];
                    if (m_cnt > 0) m_cnt--;
`endif
                end
                default: m_pc = inc;
            endcase
        end
`ifdef MCS4_PCSTACK_GUARD_EN
        if (m_ovf || m_unf) m_err = 1;
`endif
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"},    32'(pc_o),    m_pc);
        check({tag, "_depth"}, 32'(depth_o), m_cnt);
        check({tag, "_ovf"},   32'(ovf_o),   32'(m_ovf));
        check({tag, "_unf"},   32'(unf_o),   32'(m_unf));
        check({tag, "_err"},   32'(err_o),   32'(m_err));
        check({tag, "_nib"},   32'(addr_nib_o), (m_pc >> (4 * nib_sel)) & 32'hF);
    endtask

    // Drive one full instruction cycle; junk commands appear outside X2.
    task automatic instr_cycle(input bit v, input pc_cmd_t c, input int unsigned a);
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            icyc    = instr_cyc_t'(3'(p));
            nib_sel = 2'($urandom_range(0, 2));
            if (p == 6) begin
                cmd_valid = v;
                cmd       = c;
                cmd_addr  = AW'(a);
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd       = pc_cmd_t'(3'($urandom_range(0, 4)));
                cmd_addr  = AW'($urandom);
            end
            if (p == 1) check("pulse_len", {30'd0, ovf_o, unf_o}, 32'd0);
            if (p == 6) check("pc_hold", 32'(pc_o), m_pc);
        end
        model_step(v, c, a);
        @(posedge clk);
        #1;
        check_state("x3");
    endtask

    initial begin
        int unsigned r;
        rst_n = 1'b0; icyc = CYC_A1; cmd_valid = 1'b0; cmd = PC_INC;
        cmd_addr = '0; nib_sel = '0;
        model_reset();
        #12;
        check("rst_pc", 32'(pc_o), 0);
        check("rst_depth", 32'(depth_o), 0);
        check("rst_flags", {29'd0, ovf_o, unf_o, err_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle cycles, wrap, nibble select.
        for (int i = 0; i < 8; i++) begin
            instr_cycle(0, PC_INC, 0);
            check("idle_pc", 32'(pc_o), 32'(i + 1));
        end
        instr_cycle(1, PC_JUMP, 'hFFF);
        instr_cycle(1, PC_INC, 0);
        check("wrap", 32'(pc_o), 0);
        instr_cycle(1, PC_JUMP, 'h3A5);
        nib_sel = 2'd2;
        #1;
        check("nib2", 32'(addr_nib_o), 'h3);

        // Page-relative and absolute jumps.
        instr_cycle(1, PC_JUMP, 'h1FF);
        instr_cycle(1, PC_PAGE, 'h34);
        check("page_carry", 32'(pc_o), 'h234);
        instr_cycle(1, PC_JUMP, 'h150);
        instr_cycle(1, PC_PAGE, 'h34);
        check("page_same", 32'(pc_o), 'h134);
        instr_cycle(1, PC_JUMP, 'hABC);
        check("jump", 32'(pc_o), 'hABC);

        // Single call/return.
        instr_cycle(1, PC_JUMP, 'h010);
        instr_cycle(1, PC_CALL, 'h300);
        check("call_pc", 32'(pc_o), 'h300);
        check("call_depth", 32'(depth_o), 1);
        instr_cycle(1, PC_RET, 0);
        check("ret_pc", 32'(pc_o), 'h011);
        check("ret_flags", {30'd0, ovf_o, unf_o}, 0);

        // Stack overflow then drain past empty.
        instr_cycle(1, PC_JUMP, 'h100);
        instr_cycle(1, PC_CALL, 'h200);
        instr_cycle(1, PC_CALL, 'h300);
        instr_cycle(1, PC_CALL, 'h400);
        check("ovf_before", 32'(ovf_o), 0);
        instr_cycle(1, PC_CALL, 'h800);
        check("ovf4", 32'(ovf_o), 1);
        check("ovf_depth", 32'(depth_o), 3);
        instr_cycle(1, PC_RET, 0);
`ifdef MCS4_PCSTACK_GUARD_EN
        check("err_ovf", 32'(err_o), 1);
        check("ret1", 32'(pc_o), 'h301);
        instr_cycle(1, PC_RET, 0);
        check("ret2", 32'(pc_o), 'h201);
        instr_cycle(1, PC_RET, 0);
        check("ret3", 32'(pc_o), 'h101);
        instr_cycle(1, PC_RET, 0);
        check("unf4", 32'(unf_o), 1);
        check("unf_pc", 32'(pc_o), 'h102);
`else
        check("ret1", 32'(pc_o), 'h401);
        instr_cycle(1, PC_RET, 0);
        check("ret2", 32'(pc_o), 'h301);
        instr_cycle(1, PC_RET, 0);
        check("ret3", 32'(pc_o), 'h201);
        instr_cycle(1, PC_RET, 0);
        check("unf4", 32'(unf_o), 1);
        check("unf_pc", 32'(pc_o), 'h401);
`endif
        check("unf_depth", 32'(depth_o), 0);

        // Reset right after the X2 edge of a CALL aborts it.
        instr_cycle(1, PC_JUMP, 'h020);
        for (int p = 0; p < 7; p++) begin
            @(negedge clk);
            icyc = instr_cyc_t'(3'(p));
            cmd_valid = (p == 6);
            cmd = PC_CALL;
            cmd_addr = 12'h555;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort_pc", 32'(pc_o), 0);
        check("abort_depth", 32'(depth_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        icyc = CYC_X3;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_x3_pc", 32'(pc_o), 0);
        check("abort_x3_depth", 32'(depth_o), 0);
        instr_cycle(0, PC_INC, 0);
        check("abort_after", 32'(pc_o), 1);

        // Randomized command stream against the model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: instr_cycle(1, PC_INC, $urandom);
                3:       instr_cycle(1, PC_JUMP, $urandom);
                4:       instr_cycle(1, PC_PAGE, $urandom);
                5, 6:    instr_cycle(1, PC_CALL, $urandom);
                7, 8:    instr_cycle(1, PC_RET, $urandom);
                default: instr_cycle(0, pc_cmd_t'(3'($urandom_range(0, 4))), $urandom);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
